// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion used by both clock domains.
package fifo_pkg;

    localparam int PTR_MAX = 32;
    localparam int SIZE    = 8;

    typedef logic [SIZE-1:0]    ptr_t;
    typedef logic [PTR_MAX-1:0] wide_ptr_t;

    function automatic wide_ptr_t bin2gray(input wide_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic wide_ptr_t gray2bin(input wide_ptr_t g);
        wide_ptr_t b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_write_full_wptr_gray_counter.sv
// Binary/Gray pointer pair; both outputs come straight from flops so the Gray
// value can cross clock domains. Also usable as the read-side pointer.
module wptr_gray_counter
    import fifo_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            hold,
    output logic [size-1:0] bin,
    output logic [size-1:0] gray
);

    logic            adv;
    logic [size-1:0] bin_nxt;
    logic [size-1:0] gray_nxt;

    assign adv      = inc & ~hold;
    assign bin_nxt  = bin + size'(adv);
    assign gray_nxt = size'(bin2gray(PTR_MAX'(bin_nxt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
        end
    end

endmodule

// File: rtl/fifo_write_full.sv
// Write side of the async FIFO: write pointer plus registered full,
// almost-full, occupancy and sticky overflow against the synchronised read pointer.
module fifo_write_full
    import fifo_pkg::*;
#(
    parameter int size     = 8,
    parameter int AF_LEVEL = 2**(size-1) - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            winc,
    input  logic            wovf_clr,
    input  logic [size-1:0] wq2_rptr,
    output logic [size-2:0] waddr,
    output logic [size-1:0] wptr,
    output logic            wfull,
    output logic            walmost_full,
    output logic [size-1:0] wcount,
    output logic            wovf
);

    localparam logic [size-1:0] AF_THR = size'(AF_LEVEL);

    logic            wen;
    logic [size-1:0] wbin;
    logic [size-1:0] wbin_nxt;
    logic [size-1:0] wgray_nxt;
    logic [size-1:0] full_pattern;
    logic [size-1:0] rbin_s;
    logic [size-1:0] wcount_nxt;

    wptr_gray_counter #(.size(size)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (winc),
        .hold  (wfull),
        .bin   (wbin),
        .gray  (wptr)
    );

    assign wen       = winc & ~wfull;
    assign wbin_nxt  = wbin + size'(wen);
    assign wgray_nxt = size'(bin2gray(PTR_MAX'(wbin_nxt)));
    assign waddr     = wbin[size-2:0];

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits differ and the rest match.
    assign full_pattern = {~wq2_rptr[size-1:size-2], wq2_rptr[size-3:0]};
    assign rbin_s       = size'(gray2bin(PTR_MAX'(wq2_rptr)));
    assign wcount_nxt   = wbin_nxt - rbin_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            wovf         <= 1'b0;
        end else begin
            wfull        <= (wgray_nxt == full_pattern);
            walmost_full <= (wcount_nxt >= AF_THR);
            wcount       <= wcount_nxt;
            if (winc & wfull) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_full.sv
// Scoreboard bench for fifo_write_full (size=4): stimulus pushes expected
// post-edge state from a write/read count model; a monitor pops and compares.
module tb_fifo_write_full;

    localparam int SZ    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          clk;
    logic          rst_n;
    logic          winc;
    logic          wovf_clr;
    logic [SZ-1:0] wq2_rptr;
    logic [SZ-2:0] waddr;
    logic [SZ-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [SZ-1:0] wcount;
    logic          wovf;

    fifo_write_full #(.size(SZ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wovf_clr     (wovf_clr),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    typedef struct {
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic [3:0] wcount;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model: absolute counts of items written and read (read count as seen
    // through the synchroniser), plus the registered full and overflow state.
    int   wr   = 0;
    int   rd   = 0;
    bit   mFull = 0;
    bit   mOvf  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] toGray(input int b);
        logic [3:0] v;
        v = 4'(b % 16);
        return v ^ (v >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, ".wptr"},   wptr,                e.wptr);
        checkOutput({tag, ".waddr"},  {1'b0, waddr},       {1'b0, e.waddr});
        checkOutput({tag, ".wcount"}, wcount,              e.wcount);
        checkOutput({tag, ".wfull"},  {3'b0, wfull},       {3'b0, e.full});
        checkOutput({tag, ".walmost"},{3'b0, walmost_full},{3'b0, e.af});
        checkOutput({tag, ".wovf"},   {3'b0, wovf},        {3'b0, e.ovf});
    endtask

    task automatic checkZero(input string tag);
        exp_t z;
        z = '{wptr: 4'd0, waddr: 3'd0, wcount: 4'd0, full: 1'b0, af: 1'b0, ovf: 1'b0};
        checkAll(tag, z);
    endtask

    task automatic applyStimulus(input bit wincI, input bit clrI, input int rdAdv);
        exp_t e;
        int   occ;
        @(negedge clk);
        rd = rd + rdAdv;
        if (rd > wr) rd = wr;
        winc     = wincI;
        wovf_clr = clrI;
        wq2_rptr = toGray(rd);
        if (wincI && mFull) mOvf = 1;
        else if (clrI)      mOvf = 0;
        if (wincI && !mFull) wr++;
        occ   = wr - rd;
        mFull = (occ == DEPTH);
        e.wptr   = toGray(wr);
        e.waddr  = 3'(wr % DEPTH);
        e.wcount = 4'(occ);
        e.full   = mFull;
        e.af     = (occ >= AF);
        e.ovf    = mOvf;
        expQ.push_back(e);
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #2;
    endtask

    task automatic modelReset();
        wr = 0; rd = 0; mFull = 0; mOvf = 0;
        expQ.delete();
    endtask

    // Monitor: every edge the DUT presents a new registered state.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkAll("sb", e);
            end
        end
    end

    initial begin
        int rate;
        rst_n    = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        #1;
        checkZero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Fill from empty with the read side idle.
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0);
        waitEdge();
        checkOutput("af_after6", {3'b0, walmost_full}, 4'd1);
        checkOutput("full_after6", {3'b0, wfull}, 4'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0);
        waitEdge();
        checkOutput("full_after8", {3'b0, wfull}, 4'd1);
        checkOutput("wcount_full", wcount, 4'd8);
        checkOutput("wptr_full", wptr, 4'b1100);
        checkOutput("waddr_full", {1'b0, waddr}, 4'd0);

        // Writes while full must not move the pointer but must set overflow.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        waitEdge();
        checkOutput("wptr_ovf", wptr, 4'b1100);
        checkOutput("wcount_ovf", wcount, 4'd8);
        checkOutput("wovf_set", {3'b0, wovf}, 4'd1);
        applyStimulus(0, 1, 0);
        waitEdge();
        checkOutput("wovf_clr", {3'b0, wovf}, 4'd0);

        // Read side advances to binary 3 while full.
        applyStimulus(0, 0, 3);
        waitEdge();
        checkOutput("wq2_rptr_drv", wq2_rptr, 4'b0010);
        checkOutput("full_release", {3'b0, wfull}, 4'd0);
        checkOutput("wcount_rel", wcount, 4'd5);
        checkOutput("af_rel", {3'b0, walmost_full}, 4'd0);

        // Interleave up to 20 writes and drain the reads: pointers wrap.
        while (wr < 20) applyStimulus(1, 0, 1);
        while (rd < wr) applyStimulus(0, 0, 1);
        waitEdge();
        checkOutput("wptr_wrap", wptr, 4'b0110);
        checkOutput("wcount_wrap", wcount, 4'd0);
        checkOutput("full_wrap", {3'b0, wfull}, 4'd0);

        // Randomised traffic with varying read rates to hit full and empty.
        for (int seg = 0; seg < 8; seg++) begin
            rate = $urandom_range(10, 90);
            for (int i = 0; i < 50; i++) begin
                applyStimulus($urandom_range(0, 3) != 0,
                              $urandom_range(0, 15) == 0,
                              ($urandom_range(0, 99) < rate) ? $urandom_range(1, 2) : 0);
            end
        end

        // Asynchronous reset in the middle of a burst, between edges.
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        #1;
        checkZero("midreset");
        modelReset();
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        applyStimulus(1, 0, 0);
        waitEdge();
        checkOutput("wptr_postrst", wptr, 4'b0001);
        checkOutput("waddr_postrst", {1'b0, waddr}, 4'd1);
        applyStimulus(0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
